// File: rtl/psg_sound_core.sv
// psg_sound_core: SN76489-compatible sound core.
// Three square-wave tone channels and one LFSR noise channel, each with a
// 4-bit attenuation, mixed into a signed 16-bit sample. The sample is
// handed to the DAC/I2S block on each synchronized `step` rising edge.
// Optional feature macro: PSG_NOISE_EN (defined = noise channel present).
module psg_sound_core #(
    parameter int unsigned TICK_DIV = 448
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               step,
    output logic signed [15:0] waveform,
    output logic               waveform_valid
);

    localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Amplitude for attenuation n: round(8191 * 10^(-n/10)), 15 is silent.
    function automatic logic [12:0] amp_of(input logic [3:0] n);
        logic [12:0] a;
        case (n)
            4'd0:    a = 13'd8191;
            4'd1:    a = 13'd6506;
            4'd2:    a = 13'd5168;
            4'd3:    a = 13'd4105;
            4'd4:    a = 13'd3261;
            4'd5:    a = 13'd2590;
            4'd6:    a = 13'd2057;
            4'd7:    a = 13'd1634;
            4'd8:    a = 13'd1298;
            4'd9:    a = 13'd1031;
            4'd10:   a = 13'd819;
            4'd11:   a = 13'd651;
            4'd12:   a = 13'd517;
            4'd13:   a = 13'd411;
            4'd14:   a = 13'd326;
            default: a = 13'd0;
        endcase
        return a;
    endfunction

    // Tick divider
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // Register file and latch pointer
    logic [1:0] lat_ch_q, lat_ch_d;
    logic       lat_att_q, lat_att_d;
    logic [9:0] period_q [3];
    logic [9:0] period_d [3];
    logic [3:0] atten_q [4];
    logic [3:0] atten_d [4];
    logic [1:0] wr_ch;
    logic       wr_att;

    // Tone generators
    logic [9:0] tone_cnt_q [3];
    logic [9:0] tone_cnt_d [3];
    logic [2:0] tone_neg_q, tone_neg_d;

    // Mixer, output and step synchronizer
    logic [3:0]         ch_on;
    logic [3:0]         ch_neg;
    logic signed [15:0] mix_q, mix_d, mag;
    logic signed [15:0] wave_q;
    logic               valid_q;
    logic [2:0]         step_sync_q;
    logic               step_edge, load;

    // Divider counts 0..TICK_DIV-1 and pulses tick on the last count
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Decode a write: latch bytes carry their own target, data bytes use the pointer
    always_comb begin
        wr_ch     = wr_data[7] ? wr_data[6:5] : lat_ch_q;
        wr_att    = wr_data[7] ? wr_data[4]   : lat_att_q;
        lat_ch_d  = lat_ch_q;
        lat_att_d = lat_att_q;
        period_d  = period_q;
        atten_d   = atten_q;
        if (wr_en && wr_data[7]) begin
            lat_ch_d  = wr_data[6:5];
            lat_att_d = wr_data[4];
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (wr_en && !wr_att && wr_ch == 2'(i)) begin
                if (wr_data[7]) period_d[i][3:0] = wr_data[3:0];
                else            period_d[i][9:4] = wr_data[5:0];
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_en && wr_att && wr_ch == 2'(i)) atten_d[i] = wr_data[3:0];
        end
    end

    // Tone down-counters: toggle and reload on expiry, hold +1 for period 0/1
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        tone_neg_d = tone_neg_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (tick) begin
                if (period_q[i] <= 10'd1) begin
                    tone_cnt_d[i] = '0;
                    tone_neg_d[i] = 1'b0;
                end else if (tone_cnt_q[i] <= 10'd1) begin
                    tone_cnt_d[i] = period_q[i];
                    tone_neg_d[i] = ~tone_neg_q[i];
                end else begin
                    tone_cnt_d[i] = tone_cnt_q[i] - 10'd1;
                end
            end
        end
    end

`ifdef PSG_NOISE_EN
    logic [2:0]  nctl_q, nctl_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  ncnt_q, ncnt_d;
    logic [5:0]  nlast;
    logic        noise_wr, rise2, shift, fb;

    // Noise shift timing, feedback select; a control write overrides any shift
    always_comb begin
        noise_wr = wr_en && !wr_att && (wr_ch == 2'd3);
        rise2    = tick && tone_neg_q[2] && (period_q[2] > 10'd1) && (tone_cnt_q[2] <= 10'd1);
        case (nctl_q[1:0])
            2'b00:   nlast = 6'd15;
            2'b01:   nlast = 6'd31;
            default: nlast = 6'd63;
        endcase
        nctl_d = nctl_q;
        lfsr_d = lfsr_q;
        ncnt_d = ncnt_q;
        shift  = 1'b0;
        if (nctl_q[1:0] == 2'b11) begin
            shift = rise2;
        end else if (tick) begin
            if (ncnt_q >= nlast) begin
                ncnt_d = '0;
                shift  = 1'b1;
            end else begin
                ncnt_d = ncnt_q + 6'd1;
            end
        end
        fb = nctl_q[2] ? (lfsr_q[0] ^ lfsr_q[3]) : lfsr_q[0];
        if (shift) lfsr_d = {fb, lfsr_q[15:1]};
        if (noise_wr) begin
            nctl_d = wr_data[2:0];
            lfsr_d = 16'h8000;
            ncnt_d = '0;
        end
    end

    // Noise state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nctl_q <= '0;
            lfsr_q <= 16'h8000;
            ncnt_q <= '0;
        end else begin
            nctl_q <= nctl_d;
            lfsr_q <= lfsr_d;
            ncnt_q <= ncnt_d;
        end
    end

    assign ch_on  = 4'b1111;
    assign ch_neg = {~lfsr_q[0], tone_neg_q};
`else
    assign ch_on  = 4'b0111;
    assign ch_neg = {1'b0, tone_neg_q};
`endif

    // Signed sum of +/-amplitude over the enabled channels
    always_comb begin
        mix_d = '0;
        mag   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mag = $signed({3'b000, amp_of(atten_q[i])});
            if (ch_on[i]) mix_d = mix_d + (ch_neg[i] ? -mag : mag);
        end
    end

    // Output loads on a step edge or on the very first tick; both at once is one load
    always_comb begin
        step_edge = step_sync_q[1] & ~step_sync_q[2];
        load      = step_edge | (tick & ~valid_q);
    end

    // Divider, register file, tone and mixer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            lat_ch_q   <= '0;
            lat_att_q  <= 1'b0;
            period_q   <= '{default: '0};
            atten_q    <= '{default: '1};
            tone_cnt_q <= '{default: '0};
            tone_neg_q <= '0;
            mix_q      <= '0;
        end else begin
            div_q      <= div_d;
            lat_ch_q   <= lat_ch_d;
            lat_att_q  <= lat_att_d;
            period_q   <= period_d;
            atten_q    <= atten_d;
            tone_cnt_q <= tone_cnt_d;
            tone_neg_q <= tone_neg_d;
            mix_q      <= mix_d;
        end
    end

    // Step synchronizer and DAC-facing sample register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_sync_q <= '0;
            wave_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[1:0], step};
            if (load) wave_q <= mix_q;
            if (tick) valid_q <= 1'b1;
        end
    end

    assign waveform       = wave_q;
    assign waveform_valid = valid_q;

endmodule

// File: tb/tb_psg_sound_core.sv
// tb_psg_sound_core: directed, table-driven checks of psg_sound_core.
// Uses a short tick divider so multi-tick tone/noise behaviour stays short.
module tb_psg_sound_core;

    localparam int unsigned TD = 8;

`ifdef PSG_NOISE_EN
    localparam logic signed [31:0] NOISE_NEG = -32'sd8191;
`else
    localparam logic signed [31:0] NOISE_NEG = 32'sd0;
`endif

    typedef struct {
        logic [7:0]         data;
        logic signed [31:0] exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               step;
    logic signed [15:0] waveform;
    logic               waveform_valid;

    int                 n_cmp = 0;
    int                 n_bad = 0;
    int unsigned        cyc;
    int unsigned        base;
    logic signed [31:0] mag;
    logic [15:0]        m;
    vec_t               tbl [26];

    psg_sound_core #(.TICK_DIV(TD)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .step           (step),
        .waveform       (waveform),
        .waveform_valid (waveform_valid)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; ticks act on posedges where cyc is a multiple of TD
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'h90, 8191};
        tbl[1]  = '{8'h91, 6506};
        tbl[2]  = '{8'h02, 5168};
        tbl[3]  = '{8'h93, 4105};
        tbl[4]  = '{8'h04, 3261};
        tbl[5]  = '{8'h05, 2590};
        tbl[6]  = '{8'h06, 2057};
        tbl[7]  = '{8'h07, 1634};
        tbl[8]  = '{8'h08, 1298};
        tbl[9]  = '{8'h09, 1031};
        tbl[10] = '{8'h0A, 819};
        tbl[11] = '{8'h0B, 651};
        tbl[12] = '{8'h0C, 517};
        tbl[13] = '{8'h0D, 411};
        tbl[14] = '{8'h0E, 326};
        tbl[15] = '{8'h0F, 0};
        tbl[16] = '{8'hB0, 8191};
        tbl[17] = '{8'hD2, 13359};
        tbl[18] = '{8'h0B, 8842};
        tbl[19] = '{8'h9C, 9359};
        tbl[20] = '{8'hBF, 1168};
        tbl[21] = '{8'hDF, 517};
        tbl[22] = '{8'h9F, 0};
        tbl[23] = '{8'hE4, 0};
        tbl[24] = '{8'hF0, NOISE_NEG};
        tbl[25] = '{8'hFF, 0};

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        step    = 1'b0;
        #1;
        check("reset_waveform", waveform, 0);
        check("reset_valid", waveform_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First tick lands on posedge TD
        wait_cyc(TD - 1);
        check("valid_before_tick", waveform_valid, 0);
        wait_cyc(TD);
        check("valid_after_tick", waveform_valid, 1);
        check("first_tick_wave", waveform, 0);
        for (int i = 0; i < 3; i++) begin
            pulse_step();
            check($sformatf("idle_step%0d", i), waveform, 0);
        end

        // Static mixes (all tone periods 0, outputs +1)
        for (int i = 0; i < 26; i++) begin
            wr(tbl[i].data);
            pulse_step();
            check($sformatf("vec%0d", i), waveform, tbl[i].exp);
        end

        // Step held high: no further loads until a new rising edge
        step = 1'b1;
        repeat (4) @(negedge clk);
        wr(8'h90);
        repeat (10) @(negedge clk);
        check("step_held", waveform, 0);
        step = 1'b0;
        repeat (3) @(negedge clk);
        pulse_step();
        check("step_reedge", waveform, 8191);
        wr(8'h9F);

        // Tone ch0 period 16: write of 0x01 lands 4 cycles before a tick
        base = (cyc / TD + 2) * TD + 2;
        wait_cyc(base);
        wr(8'h80);
        wr(8'h01);
        wr(8'h90);
        base = base + 6;
        for (int j = 0; j < 8; j++) begin
            wait_cyc(base + 128 * j + 60);
            pulse_step();
            check($sformatf("tone_half%0d", j), waveform, (j % 2 == 0) ? -8191 : 8191);
        end
        wr(8'h9F);
        wr(8'h80);
        wr(8'h00);

`ifdef PSG_NOISE_EN
        // White noise, rate 00: E4 lands 4 cycles before a tick
        base = (cyc / TD + 2) * TD + 7;
        wait_cyc(base);
        wr(8'h9F);
        wr(8'hBF);
        wr(8'hDF);
        wr(8'hF0);
        wr(8'hE4);
        base = base + 5;
        m = 16'h8000;
        for (int k = 0; k < 16; k++) begin
            wait_cyc(base + 128 * k + 60);
            pulse_step();
            check($sformatf("noise_shift%0d", k), waveform, m[0] ? 8191 : -8191);
            m = {m[0] ^ m[3], m[15:1]};
        end
        wait_cyc(base + 1920 + 70);
        wr(8'h90);
        wr(8'hB0);
        wr(8'hD0);
        wait_cyc(base + 1920 + 80);
        pulse_step();
        check("all_four_max", waveform, 32764);
`else
        // No noise channel: ch3 contributes nothing, noise writes only move the pointer
        wr(8'h9F);
        wr(8'hBF);
        wr(8'hDF);
        wr(8'hF0);
        wr(8'hE4);
        pulse_step();
        check("noise_absent", waveform, 0);
        wr(8'h90);
        wr(8'hB0);
        wr(8'hD0);
        wr(8'hE4);
        wr(8'h05);
        pulse_step();
        check("three_tones_max", waveform, 24573);
`endif
        wr(8'h9F);
        wr(8'hBF);
        wr(8'hDF);
        wr(8'hFF);

        // Reset in the middle of a running tone with step active
        wr(8'h80);
        wr(8'h01);
        wr(8'h90);
        repeat (20) @(negedge clk);
        pulse_step();
        mag = waveform;
        if (mag < 0) mag = -mag;
        check("pre_reset_mag", mag, 8191);
        step = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_wave", waveform, 0);
        check("midreset_valid", waveform_valid, 0);
        repeat (2) @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(TD - 1);
        check("rst2_valid_before", waveform_valid, 0);
        wait_cyc(TD);
        check("rst2_valid_after", waveform_valid, 1);
        check("rst2_first_wave", waveform, 0);
        wait_cyc(200);
        pulse_step();
        check("rst2_step", waveform, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
